// File: rtl/cache_pkg.sv
// Shared types and constants for the cache/memory arbiter.
// Block geometry helpers used by the fill sequencer.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      I_FILL,
      D_FILL,
      D_WRITE,
      WAIT_RET,
      TAG
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   localparam int WORD_STEP = 2;

   function automatic int block_mask(input int wpb);
      return WORD_STEP * wpb - 1;
   endfunction

   localparam int BLOCK_OFFSET_MASK = block_mask(8);

endpackage

// File: rtl/cache_mem_arbiter_fill_sequencer.sv
// Issue/return counters and word address generation for one block fill.
// Shared by both cache sides; reloaded on every fill grant.
module fill_sequencer
   import cache_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic              issue_en,
   input  logic              ret_en,
   output logic [ADDR_W-1:0] issue_addr,
   output logic [ADDR_W-1:0] ret_addr,
   output logic              issue_last,
   output logic              ret_last,
   output logic              ret_full
);

   localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
   localparam logic [ADDR_W-1:0] MASK =
      ADDR_W'(block_mask(WORDS_PER_BLOCK));
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_STEP);

   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  ret_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         base      <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else if (start) begin
         base      <= addr & ~MASK;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         if (issue_en)
            issue_cnt <= issue_cnt + 1'b1;
         if (ret_en)
            ret_cnt <= ret_cnt + 1'b1;
      end
   end

   assign issue_addr = base + STEP * ADDR_W'(issue_cnt);
   assign ret_addr   = base + STEP * ADDR_W'(ret_cnt);

   assign issue_last = issue_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
   assign ret_last   = ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
   assign ret_full   = ret_cnt == CNT_W'(WORDS_PER_BLOCK);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache fills and D write-through onto one memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module cache_mem_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MEM_LAT         = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              i_fill_we,
   output logic              d_fill_we,
   output logic              i_tag_we,
   output logic              d_tag_we,
   output logic              i_busy,
   output logic              d_busy,
   output logic              d_wr_ack
);

   // Returns can only complete during issue when latency is under a block.
   localparam bit EARLY_RET = MEM_LAT < WORDS_PER_BLOCK;

   arb_state_t        state;
   grant_t            grant;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              pick_i;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              filling;
   logic              fill_phase;
   logic              accept;
   logic              ret_fin;
   logic              done;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] ret_addr;
   logic              issue_last;
   logic              ret_last;
   logic              ret_full;

`ifdef ARB_ROUND_ROBIN_EN
   assign pick_i = i_req && (!d_req || grant == GNT_D);
`else
   assign pick_i = i_req;
`endif

   assign start = (state == IDLE) &&
                  (pick_i || (d_req && !d_wr));
   assign start_addr = pick_i ? i_addr : d_addr;

   assign filling    = (state == I_FILL) || (state == D_FILL);
   assign fill_phase = filling || (state == WAIT_RET) ||
                       (state == TAG);

   assign accept  = fill_phase && mem_valid && !ret_full;
   assign ret_fin = accept && ret_last;
   assign done    = ret_fin || ret_full;

   fill_sequencer #(
      .ADDR_W          (ADDR_W),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .addr       (start_addr),
      .issue_en   (filling),
      .ret_en     (accept),
      .issue_addr (issue_addr),
      .ret_addr   (ret_addr),
      .issue_last (issue_last),
      .ret_last   (ret_last),
      .ret_full   (ret_full)
   );

   // grant doubles as the last-grant record; reset to D so I wins first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= GNT_D;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_i) begin
                  grant <= GNT_I;
                  state <= I_FILL;
               end else if (d_req) begin
                  grant <= GNT_D;
                  if (d_wr) begin
                     state   <= D_WRITE;
                     wr_addr <= d_addr;
                     wr_data <= d_wdata;
                  end else begin
                     state <= D_FILL;
                  end
               end
            end
            I_FILL, D_FILL: begin
               if (issue_last)
                  state <= (EARLY_RET && done) ? TAG : WAIT_RET;
            end
            WAIT_RET: begin
               if (done)
                  state <= TAG;
            end
            D_WRITE: state <= IDLE;
            TAG:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_en    = filling || (state == D_WRITE);
   assign mem_wr    = state == D_WRITE;
   assign mem_wdata = (state == D_WRITE) ? wr_data : '0;
   assign d_wr_ack  = state == D_WRITE;

   always_comb begin
      mem_addr = '0;
      if (filling)
         mem_addr = issue_addr;
      else if (state == D_WRITE)
         mem_addr = wr_addr;
   end

   assign fill_data = accept ? mem_rdata : '0;
   assign fill_addr = accept ? ret_addr : '0;
   assign i_fill_we = accept && (grant == GNT_I);
   assign d_fill_we = accept && (grant == GNT_D);

   assign i_tag_we = (state == TAG) && (grant == GNT_I);
   assign d_tag_we = (state == TAG) && (grant == GNT_D);

   assign i_busy = i_req ||
                   ((state != IDLE) && (grant == GNT_I));
   assign d_busy = d_req ||
                   ((state != IDLE) && (grant == GNT_D));

endmodule
